mod_n_updown_counter: RTL and testbench

- Parametrised modulo-N synchronous counter.
- Counts up or down, with enable, parallel load and a terminal-count carry so instances cascade into multi-digit counters.
- Serves as the general counter primitive for the counters library; default configuration is modulo-7.
- Built from a bank of toggle cells, with toggle enables derived from the count state.

---
 rtl/counter_pkg.sv | 23 ++
 rtl/mod_n_updown_counter_tff_cell.sv | 18 +
 rtl/mod_n_updown_counter.sv | 114 +++++++++++
 tb/tb_mod_n_updown_counter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counters library.
//   DIR_UP / DIR_DOWN : encodings of the up_dn input.
//   clog2             : minimum register width needed to hold a value.
//   modulus_ok        : legality check for a MODULUS/WIDTH pairing.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of bits needed to represent values 0 .. v-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // MODULUS must lie in 2 .. 2^WIDTH.
  function automatic bit modulus_ok(input int unsigned modulus, input int unsigned width);
    return (modulus >= 2) && (64'(modulus) <= (64'(1) << width));
  endfunction

endpackage

// File: rtl/mod_n_updown_counter_tff_cell.sv
// Single toggle flip-flop: q inverts on each rising clk while t is high.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, q -> 0
//   t     : toggle enable
//   q     : stored bit
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-MODULUS up/down counter with enable, parallel load and terminal-count carry.
// The count lives in a bank of toggle cells; each cell toggles where the decoded
// next count differs from the present count, so no out-of-range value is ever held.
//   clk, rst_n : clock, asynchronous active-low reset
//   sync_clr   : synchronous clear, highest priority (only with MOD_N_COUNTER_SYNC_CLR_EN)
//   en         : count enable
//   up_dn      : 1 = up, 0 = down
//   load       : synchronous load strobe, load_val applied
//   count      : current count (registered)
//   tc         : terminal-count carry (combinational), drives the next stage's en
//   wrap       : one-cycle pulse after a wrap (registered)
//   load_err   : one-cycle pulse after an out-of-range load (registered)
// Optional feature macro: MOD_N_COUNTER_SYNC_CLR_EN
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 7
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MOD_N_COUNTER_SYNC_CLR_EN
  input  logic             sync_clr,
`endif
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  if (!modulus_ok(MODULUS, WIDTH)) begin : g_bad_param
    $error("mod_n_updown_counter: MODULUS must be in 2 .. 2**WIDTH");
  end

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] tgl;
  logic             wrap_d;
  logic             err_d;
  logic             clr;
  logic             at_end;

`ifdef MOD_N_COUNTER_SYNC_CLR_EN
  assign clr = sync_clr;
`else
  assign clr = 1'b0;
`endif

  // Terminal count for the current direction.
  assign at_end = (up_dn == DIR_UP) ? (count == MAX_C) : (count == '0);
  assign tc     = en & ~load & ~clr & at_end;

  // Next-count decode: clear > load > enable > hold.
  always_comb begin
    nxt    = count;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        nxt = load_val;
      end else begin
        nxt   = '0;
        err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (count == MAX_C) begin
          nxt    = '0;
          wrap_d = 1'b1;
        end else begin
          nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          nxt    = MAX_C;
          wrap_d = 1'b1;
        end else begin
          nxt = count - WIDTH'(1);
        end
      end
    end
  end

  assign tgl = count ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (tgl[i]),
      .q     (count[i])
    );
  end

  // Event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_d;
      load_err <= err_d;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench for mod_n_updown_counter: a modulo-7 instance and a modulo-8
// instance share the stimulus and are checked against an arithmetic model; a pair of
// modulo-10 instances forms a two-digit cascade.
module tb_mod_n_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       sclr;
  logic       en, up_dn, load;
  logic [2:0] load_val;
  logic [2:0] count, count8;
  logic       tc, wrap, load_err;
  logic       tc8, wrap8, load_err8;

  logic       c_en;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, lo_wrap, lo_err, hi_tc, hi_wrap, hi_err;

  int n_cmp;
  int n_bad;

  int m_cnt, m8_cnt;
  bit m_wrap, m_err, m8_wrap, m8_err;

  mod_n_updown_counter dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MOD_N_COUNTER_SYNC_CLR_EN
    .sync_clr(sclr),
`endif
    .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
`ifdef MOD_N_COUNTER_SYNC_CLR_EN
    .sync_clr(sclr),
`endif
    .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count8), .tc(tc8), .wrap(wrap8), .load_err(load_err8)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst_n(rst_n),
`ifdef MOD_N_COUNTER_SYNC_CLR_EN
    .sync_clr(1'b0),
`endif
    .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
    .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_err)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst_n(rst_n),
`ifdef MOD_N_COUNTER_SYNC_CLR_EN
    .sync_clr(1'b0),
`endif
    .en(lo_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
    .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on integers.
  function automatic int mdl_next(int c, int m, bit sc, bit e, bit u, bit l, int lv);
    if (sc) return 0;
    if (l)  return (lv < m) ? lv : 0;
    if (e)  return u ? (c + 1) % m : (c + m - 1) % m;
    return c;
  endfunction

  function automatic bit mdl_term(int c, int m, bit sc, bit e, bit u, bit l);
    return !sc && !l && e && (u ? (c == m - 1) : (c == 0));
  endfunction

  function automatic bit mdl_err(int m, bit sc, bit l, int lv);
    return !sc && l && (lv >= m);
  endfunction

  // Advance both models by one clock edge with the inputs currently applied.
  task automatic model_edge(input bit sc, input bit e, input bit u, input bit l, input int lv);
    m_wrap  = mdl_term(m_cnt, 7, sc, e, u, l);
    m_err   = mdl_err(7, sc, l, lv);
    m_cnt   = mdl_next(m_cnt, 7, sc, e, u, l, lv);
    m8_wrap = mdl_term(m8_cnt, 8, sc, e, u, l);
    m8_err  = mdl_err(8, sc, l, lv);
    m8_cnt  = mdl_next(m8_cnt, 8, sc, e, u, l, lv);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".count"},     int'(count),     m_cnt);
    check({tag, ".wrap"},      int'(wrap),      int'(m_wrap));
    check({tag, ".load_err"},  int'(load_err),  int'(m_err));
    check({tag, ".count8"},    int'(count8),    m8_cnt);
    check({tag, ".wrap8"},     int'(wrap8),     int'(m8_wrap));
    check({tag, ".load_err8"}, int'(load_err8), int'(m8_err));
  endtask

  // One edge: drive on the falling edge, check tc before and registers after the rising edge.
  // xc >= 0 additionally checks the mod-7 count against a hand-derived value.
  task automatic step(input string tag, input bit sc, input bit e, input bit u,
                      input bit l, input int lv, input int xc);
    @(negedge clk);
    sclr = sc; en = e; up_dn = u; load = l; load_val = 3'(lv);
    #1;
    check({tag, ".tc"},  int'(tc),  int'(mdl_term(m_cnt, 7, sc, e, u, l)));
    check({tag, ".tc8"}, int'(tc8), int'(mdl_term(m8_cnt, 8, sc, e, u, l)));
    @(posedge clk);
    model_edge(sc, e, u, l, lv);
    #1;
    check_regs(tag);
    if (xc >= 0) check({tag, ".fixed"}, int'(count), xc);
  endtask

  initial begin
    int up_seq[9];
    int dn_seq[5];
    int hi_wraps;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; sclr = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 3'd0;
    c_en = 1'b0;
    m_cnt = 0; m8_cnt = 0; m_wrap = 0; m_err = 0; m8_wrap = 0; m8_err = 0;
    up_seq = '{1, 2, 3, 4, 5, 6, 0, 1, 2};
    dn_seq = '{0, 6, 5, 6, 0};

    #12;
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Count to 4, then an asynchronous reset between edges.
    for (int i = 1; i <= 4; i++) step("pre_rst", 1'b0, 1'b1, 1'b1, 1'b0, 0, i);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_cnt = 0; m8_cnt = 0; m_wrap = 0; m_err = 0; m8_wrap = 0; m8_err = 0;
    check_regs("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 1'b1, 1'b1, 1'b0, 0);
    #1;
    check_regs("rst_release");
    check("rst_release.fixed", int'(count), 1);

    // Up wrap from 0.
    step("ld0", 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 9; i++) step("up", 1'b0, 1'b1, 1'b1, 1'b0, 0, up_seq[i]);

    // Down wrap from 1, then flip direction.
    step("ld1", 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
    for (int i = 0; i < 3; i++) step("down", 1'b0, 1'b1, 1'b0, 1'b0, 0, dn_seq[i]);
    for (int i = 3; i < 5; i++) step("flip", 1'b0, 1'b1, 1'b1, 1'b0, 0, dn_seq[i]);
    check("flip.wrap_fixed", int'(wrap), 1);

    // Loads, in and out of range, with and without en.
    step("ld5",    1'b0, 1'b1, 1'b1, 1'b1, 5, 5);
    check("ld5.err_fixed", int'(load_err), 0);
    step("ld7",    1'b0, 1'b1, 1'b1, 1'b1, 7, 0);
    check("ld7.err_fixed", int'(load_err), 1);
    step("after7", 1'b0, 1'b1, 1'b1, 1'b0, 0, 1);
    check("after7.err_fixed", int'(load_err), 0);
    step("ld4_noen", 1'b0, 1'b0, 1'b0, 1'b1, 4, 4);
    step("hold",   1'b0, 1'b0, 1'b1, 1'b0, 0, 4);

    // Random mix of count, hold and load.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)), -1);
    end

`ifdef MOD_N_COUNTER_SYNC_CLR_EN
    step("sc_ld4", 1'b0, 1'b0, 1'b1, 1'b1, 4, 4);
    step("sclr",   1'b1, 1'b1, 1'b1, 1'b1, 3, 0);
    check("sclr.err_fixed", int'(load_err), 0);
    step("sclr_up", 1'b0, 1'b1, 1'b1, 1'b0, 0, 1);
`endif

    // Two-digit decimal cascade.
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    check("casc.start", int'(hi_count) * 10 + int'(lo_count), 0);
    c_en = 1'b1;
    hi_wraps = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      check("casc.value", int'(hi_count) * 10 + int'(lo_count), i % 100);
      if (hi_wrap) hi_wraps++;
    end
    @(negedge clk);
    c_en = 1'b0;
    check("casc.hi_wraps", hi_wraps, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
